// File: rtl/spi_fifo_pkg.sv
// spi_fifo_pkg: shared state encoding, default sizes and frame-length helper for spi_fifo_master.
package spi_fifo_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;
  localparam int DEF_ADDR_BITS = 8;
  localparam int DEF_DATA_BITS = 16;
  localparam int DEF_CLK_RATIO = 8;
  localparam int DEF_DATA_SIZE = 32;
  localparam int DEF_FIFO_SIZE = 8;
  function automatic int frame_bits(input int addr_bits, input int data_bits);
    return addr_bits + data_bits;
  endfunction
endpackage

// File: rtl/spi_tx_fifo.sv
// spi_tx_fifo: synchronous transmit FIFO; head word readable in place, flags decoded from a registered count.
module spi_tx_fifo #(
  parameter int DATA_SIZE = 32,
  parameter int FIFO_SIZE = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         i_push,
  input  logic [DATA_SIZE-1:0]         i_data,
  input  logic                         i_pop,
  output logic [DATA_SIZE-1:0]         o_head,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(FIFO_SIZE):0]   o_count
);
  localparam int AW = $clog2(FIFO_SIZE);
  localparam int CW = AW + 1;
  logic [DATA_SIZE-1:0] r_mem [FIFO_SIZE];
  logic [AW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_count;
  logic w_push, w_pop;
  assign o_full  = r_count == CW'(FIFO_SIZE);
  assign o_empty = r_count == '0;
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd];
  // a push into a full FIFO is dropped even when a pop happens in the same cycle
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop) r_rd <= r_rd + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end
endmodule

// File: rtl/spi_fifo_master.sv
// spi_fifo_master: FIFO-fed write-only SPI master sending {addr, data} frames.
// Define FIFO_LEVEL_EN to expose the registered FIFO word count on fifo_level.
module spi_fifo_master
  import spi_fifo_pkg::*;
#(
  parameter int DATA_BITS = DEF_DATA_BITS,
  parameter int ADDR_BITS = DEF_ADDR_BITS,
  parameter int CLK_RATIO = DEF_CLK_RATIO,
  parameter int DATA_SIZE = DEF_DATA_SIZE,
  parameter int FIFO_SIZE = DEF_FIFO_SIZE
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [7:0]           clk_ratio,
  input  logic                 fifo_wren,
  input  logic [DATA_SIZE-1:0] data_in,
  output logic                 busy,
  output logic                 data_full,
  output logic                 data_empty,
  output logic                 done,
  output logic                 SEN,
  output logic                 SCLK,
`ifdef FIFO_LEVEL_EN
  output logic [$clog2(FIFO_SIZE):0] fifo_level,
`endif
  output logic                 SDATA
);
  localparam int N  = frame_bits(ADDR_BITS, DATA_BITS);
  localparam int HW = $clog2(2 * N + 1);
  localparam logic [HW-1:0] LAST_HALF = HW'(2 * N);
  state_t r_state, w_next;
  logic [7:0] r_r, r_cnt, w_r;
  logic [HW-1:0] r_half;
  logic [N-1:0] r_shift, w_frame;
  logic [DATA_SIZE-1:0] w_head;
  logic [$clog2(FIFO_SIZE):0] w_count;
  logic r_busy, r_done, r_sen, r_sclk, r_sdata;
  logic w_tick, w_go, w_end, w_unused;
  spi_tx_fifo #(.DATA_SIZE(DATA_SIZE), .FIFO_SIZE(FIFO_SIZE)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (fifo_wren),
    .i_data  (data_in),
    .i_pop   (r_state == LOAD),
    .o_head  (w_head),
    .o_full  (data_full),
    .o_empty (data_empty),
    .o_count (w_count)
  );
`ifdef FIFO_LEVEL_EN
  assign fifo_level = w_count;
`endif
  assign w_unused = &{1'b0, w_head[DATA_SIZE-1:N], w_count};
  assign w_frame  = {w_head[ADDR_BITS-1:0], w_head[ADDR_BITS+DATA_BITS-1:ADDR_BITS]};
  assign w_r      = clk_ratio == '0 ? 8'(CLK_RATIO) : clk_ratio;
  assign w_tick   = r_cnt == r_r - 8'd1;
  // the LOAD cycle is the first cycle of the first SCLK-low phase, so SEN low spans exactly R*(2N+1)
  assign w_go  = !data_empty && ((r_state == IDLE && start) || (r_state == GAP && w_tick));
  assign w_end = data_empty && r_state == GAP && w_tick;
  assign busy  = r_busy;
  assign done  = r_done;
  assign SEN   = r_sen;
  assign SCLK  = r_sclk;
  assign SDATA = r_sdata;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = w_go ? LOAD :
             w_end ? IDLE :
             r_state == LOAD ? SHIFT :
             (r_state == SHIFT && w_tick && r_half == LAST_HALF) ? GAP : r_state;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sen   <= 1'b1;
      r_sclk  <= 1'b0;
      r_sdata <= 1'b0;
      r_r     <= 8'd1;
      r_cnt   <= '0;
      r_half  <= '0;
      r_shift <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_go) begin
        r_busy  <= 1'b1;
        r_sen   <= 1'b0;
        r_sclk  <= 1'b0;
        r_sdata <= w_frame[N-1];
        r_r     <= w_r;
        r_cnt   <= '0;
        r_half  <= '0;
      end else if (w_end) begin
        r_busy <= 1'b0;
      end else if (r_state == LOAD || r_state == SHIFT) begin
        if (r_state == LOAD) r_shift <= w_frame;
        if (!w_tick) begin
          r_cnt <= r_cnt + 8'd1;
        end else if (r_half == LAST_HALF) begin
          r_cnt   <= '0;
          r_sen   <= 1'b1;
          r_sclk  <= 1'b0;
          r_sdata <= 1'b0;
          r_done  <= 1'b1;
        end else begin
          r_cnt  <= '0;
          r_half <= r_half + HW'(1);
          r_sclk <= ~r_half[0];
          if (r_half[0]) begin
            r_shift <= r_shift << 1;
            r_sdata <= r_shift[N-2];
          end
        end
      end else if (r_state == GAP) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_spi_fifo_master.sv
// tb_spi_fifo_master: randomized stimulus with a frame scoreboard; a monitor decodes SEN/SCLK/SDATA and checks each frame.
module tb_spi_fifo_master;
  logic clock = 0, reset = 0, start = 0, fifo_wren = 0;
  logic [7:0] clk_ratio = 0;
  logic [31:0] data_in = 0;
  logic busy, data_full, data_empty, done, SEN, SCLK, SDATA;
`ifdef FIFO_LEVEL_EN
  logic [3:0] fifo_level;
`endif
  typedef struct {
    logic [23:0] bits;
    int r;
  } frame_t;
  frame_t exp_q[$];
  int n_checks = 0, n_pass = 0;
  int cur_r = 8;
  int n_done = 0, n_frames = 0, sclk_rises = 0;

  spi_fifo_master dut (
    .clock(clock), .reset(reset), .start(start), .clk_ratio(clk_ratio),
    .fifo_wren(fifo_wren), .data_in(data_in), .busy(busy), .data_full(data_full),
    .data_empty(data_empty), .done(done), .SEN(SEN), .SCLK(SCLK),
`ifdef FIFO_LEVEL_EN
    .fifo_level(fifo_level),
`endif
    .SDATA(SDATA)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic set_ratio(input int r);
    clk_ratio = 8'(r);
    cur_r = (r == 0) ? 8 : r;
  endtask

  // a word that fits is expected back as {addr byte, data halfword}, sent at the current ratio
  task automatic push(input logic [31:0] w, input bit accept);
    fifo_wren = 1;
    data_in = w;
    tick;
    fifo_wren = 0;
    if (accept) exp_q.push_back('{bits: {w[7:0], w[23:8]}, r: cur_r});
  endtask

  task automatic pulse_start;
    start = 1;
    tick;
    start = 0;
    check("busy_rise", busy, 1);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && busy; i++) tick;
    check("idle_reached", busy, 0);
    check("empty_after_drain", data_empty, 1);
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  initial begin : monitor
    logic p_sen, p_sclk, in_frame, have_prev;
    logic [23:0] cap;
    int low_cnt, high_cnt, rises, gap_cnt, prev_r;
    frame_t e;
    p_sen = 1; p_sclk = 0; in_frame = 0; have_prev = 0; cap = 0;
    low_cnt = 0; high_cnt = 0; rises = 0; gap_cnt = 0; prev_r = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        in_frame = 0; have_prev = 0; p_sen = 1; p_sclk = 0;
      end else begin
        if (done) n_done++;
        if (SCLK && !p_sclk) sclk_rises++;
        if (!SEN && p_sen) begin
          check("busy_during_frame", busy, 1);
          if (have_prev) check("gap_len", gap_cnt, prev_r);
          in_frame = 1; low_cnt = 0; high_cnt = 0; rises = 0; cap = 0;
        end
        if (!SEN && in_frame) begin
          low_cnt++;
          if (SCLK) high_cnt++;
          if (SCLK && !p_sclk) begin
            rises++;
            cap = {cap[22:0], SDATA};
          end
        end
        if (SEN && !p_sen && in_frame) begin
          in_frame = 0;
          n_frames++;
          check("done_pulse", done, 1);
          check("frame_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("frame_bits", cap, e.bits);
            check("sclk_rises", rises, 24);
            check("sen_low_cycles", low_cnt, e.r * 49);
            check("sclk_high_cycles", high_cnt, e.r * 24);
            prev_r = e.r;
          end
          have_prev = 1;
          gap_cnt = 0;
        end
        if (SEN && have_prev) gap_cnt++;
        if (!busy) have_prev = 0;
        p_sen = SEN;
        p_sclk = SCLK;
      end
    end
  end

  initial begin
    int d0, k, r0;
    logic [31:0] w;
    #2 reset = 1;
    #1;
    check("rst_sen", SEN, 1);
    check("rst_sclk", SCLK, 0);
    check("rst_sdata", SDATA, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_empty", data_empty, 1);
    check("rst_full", data_full, 0);
    tick; tick;
    reset = 0;
    tick;

    set_ratio(2);
    start = 1;
    tick; tick;
    start = 0;
    check("start_on_empty_busy", busy, 0);
    check("start_on_empty_sen", SEN, 1);

    push(32'h00ABCD5A, 1);
    pulse_start;
    wait_idle(400);

    set_ratio(0);
    push($urandom, 1);
    pulse_start;
    wait_idle(600);

    set_ratio(3);
    d0 = n_done;
    for (int i = 0; i < 3; i++) push($urandom, 1);
    pulse_start;
    wait_idle(800);
    check("b2b_done_count", n_done - d0, 3);

    set_ratio(1);
    for (int i = 0; i < 9; i++) begin
      push($urandom, i < 8);
      if (i == 7) begin
        check("full_after_8", data_full, 1);
        check("not_empty_after_8", data_empty, 0);
`ifdef FIFO_LEVEL_EN
        check("level_after_8", fifo_level, 8);
`endif
      end
    end
    check("full_after_9", data_full, 1);
    pulse_start;
    wait_idle(1000);

    set_ratio(2);
    push($urandom, 1);
    pulse_start;
    repeat (40) tick;
    check("busy_mid_frame", busy, 1);
    push($urandom, 1);
    wait_idle(600);

    for (int n = 0; n < 4; n++) begin
      set_ratio($urandom_range(0, 5));
      k = $urandom_range(1, 4);
      for (int i = 0; i < k; i++) begin
        w = $urandom;
        push(w, 1);
      end
      pulse_start;
      wait_idle(k * 500 + 100);
    end

    set_ratio(2);
    push($urandom, 1);
    push($urandom, 1);
    pulse_start;
    repeat (30) tick;
    #2 reset = 1;
    #1;
    check("midrst_sen", SEN, 1);
    check("midrst_sclk", SCLK, 0);
    check("midrst_busy", busy, 0);
    check("midrst_empty", data_empty, 1);
    exp_q.delete();
    repeat (3) tick;
    #3 reset = 0;
    r0 = sclk_rises;
    repeat (60) tick;
    check("no_sclk_after_rst", sclk_rises - r0, 0);
    check("post_rst_sen", SEN, 1);
    check("post_rst_busy", busy, 0);
    check("done_vs_frames", n_done, n_frames);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
